// File: rtl/conv1d_pkg.sv
// Shared types and constants for the conv1d branch datapath.
// The accumulator FSM states and the tap-select width live here.
package conv1d_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_HOLD} acc_state_e;

  localparam int SEL_W        = 3;
  localparam int TAPS_DEFAULT = 5;

  // Smallest accumulator that holds TAPS full-scale products plus a full-scale bias.
  function automatic int acc_width_min(input int width, input int taps);
    return 4 * width + $clog2(taps + 1);
  endfunction

endpackage

// File: rtl/conv_tap_accumulator.sv
// Walks the branch tap select and sums bias plus TAPS products.
// The result is handed out on a valid/ready port.
module conv_tap_accumulator
  import conv1d_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int TAPS      = TAPS_DEFAULT,
  parameter int ACC_WIDTH = 4 * WIDTH + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [4*WIDTH-1:0]   bias,
  output logic [SEL_W-1:0]     sel,
  input  logic [4*WIDTH-1:0]   prod,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data
);

  localparam logic [SEL_W-1:0] LAST_TAP = SEL_W'(TAPS - 1);

  if (ACC_WIDTH < acc_width_min(WIDTH, TAPS)) begin : g_acc_width_check
    $error("conv_tap_accumulator: ACC_WIDTH too small for TAPS products plus bias");
  end
  if (TAPS < 1 || TAPS > 8) begin : g_taps_check
    $error("conv_tap_accumulator: TAPS must be within 1..8");
  end

  acc_state_e           state;
  logic [SEL_W-1:0]     tap;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_sum;

  assign acc_sum = acc + ACC_WIDTH'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tap       <= '0;
      sel       <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (abort) begin
      // out_data is deliberately left alone so the last good result stays visible.
      state     <= ST_IDLE;
      tap       <= '0;
      sel       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc   <= ACC_WIDTH'(bias);
            tap   <= '0;
            sel   <= '0;
            busy  <= 1'b1;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc <= acc_sum;
          if (tap == LAST_TAP) begin
            out_data  <= acc_sum;
            out_valid <= 1'b1;
            tap       <= '0;
            sel       <= '0;
            state     <= ST_HOLD;
          end else begin
            // sel leads by one register stage so it equals tap during the next cycle.
            tap <= tap + 1'b1;
            sel <= tap + 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
